mux_8x1_rr: RTL



---
 rtl/mux_8x1_rr.sv | 118 +++++++++++
 1 files changed

// File: rtl/mux_8x1_rr.sv
// mux_8x1_rr: eight valid/ready lanes collected onto one registered stream with
// round-robin arbitration. Each output word carries its source lane index on S so
// a downstream 1x8 demux can route it back.
//
// Optional build macro MUX_PKT_LOCK_EN: adds in_last/out_last and locks the arbiter
// to one lane until that lane delivers a word marked last.
module mux_8x1_rr #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [8*DATA_W-1:0] in_data,
    input  logic [7:0]          in_valid,
    output logic [7:0]          in_ready,
`ifdef MUX_PKT_LOCK_EN
    input  logic [7:0]          in_last,
    output logic                out_last,
`endif
    output logic [DATA_W-1:0]   D,
    output logic [2:0]          S,
    output logic                out_valid,
    input  logic                out_ready
);

    logic [DATA_W-1:0] lane_data [8];
    logic [DATA_W-1:0] d_q;
    logic [2:0]        s_q;
    logic              valid_q;
    logic [2:0]        ptr_q;
    logic              ld;
    logic              gnt_found;
    logic [2:0]        gnt_idx;
    logic [2:0]        cand;

`ifdef MUX_PKT_LOCK_EN
    logic              lock_q;
    logic [2:0]        lock_lane_q;
    logic              last_q;
`endif

    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign lane_data[i] = in_data[i*DATA_W +: DATA_W];
    end

    // Output register may take a new word when empty or being drained this cycle.
    assign ld = ~rst & (~valid_q | out_ready);

    // Round-robin search starting at ptr; descending loop so the nearest lane wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 3'd0;
        cand      = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            cand = ptr_q + 3'(k);
            if (in_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
`ifdef MUX_PKT_LOCK_EN
        // Mid-packet only the locked lane may be granted; others wait.
        if (lock_q) begin
            gnt_found = in_valid[lock_lane_q];
            gnt_idx   = lock_lane_q;
        end
`endif
    end

    // Acknowledge only the granted lane, and only when the output can load.
    always_comb begin
        in_ready = 8'h00;
        if (ld && gnt_found) begin
            in_ready = 8'b1 << gnt_idx;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q     <= '0;
            s_q     <= 3'd0;
            valid_q <= 1'b0;
            ptr_q   <= 3'd0;
        end else if (ld) begin
            if (gnt_found) begin
                d_q     <= lane_data[gnt_idx];
                s_q     <= gnt_idx;
                valid_q <= 1'b1;
                ptr_q   <= gnt_idx + 3'd1;
            end else begin
                // D/S keep their last values; only the valid flag drops.
                valid_q <= 1'b0;
            end
        end
    end

`ifdef MUX_PKT_LOCK_EN
    // Packet lock: set by a non-last accept, cleared by a last accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q      <= 1'b0;
            lock_lane_q <= 3'd0;
            last_q      <= 1'b0;
        end else if (ld && gnt_found) begin
            lock_q      <= ~in_last[gnt_idx];
            lock_lane_q <= gnt_idx;
            last_q      <= in_last[gnt_idx];
        end
    end

    assign out_last = last_q;
`endif

    assign D         = d_q;
    assign S         = s_q;
    assign out_valid = valid_q;

endmodule
